// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus responder for a 128 KB RAM and an MMIO window with RX/TX FIFOs, a cycle counter and a program-stop strobe.
// Define MEMIO_CYCLE_SNAPSHOT_EN to latch the counter on a 0x30004 read, so the following byte reads return one coherent value.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_addr,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  logic [7:0]    r_ram [0:(2**RAM_ADDR_WIDTH)-1];
  logic [7:0]    r_rx_mem [0:DEPTH-1];
  logic [7:0]    r_tx_mem [0:DEPTH-1];
  logic [7:0]    r_ram_rd;
  logic          r_sel_ram;
  logic [7:0]    r_io_q;
  logic [PW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [31:0]   r_cnt;
  logic          r_prog_stop, r_tx_ovf;
  logic w_io, w_ram, w_reg0, w_reg_stop, w_cnt, w_rd, w_wr;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
  logic w_tx_empty, w_tx_full, w_tx_req, w_tx_push, w_tx_pop;
  logic [7:0]  w_cnt_byte, w_io_rd;
  logic [31:0] w_cnt_word;
  logic        w_unused;
  assign w_unused   = ^mem_addr[31:18];
  assign w_io       = mem_addr[17:16] == 2'b11;
  assign w_ram      = !mem_addr[17];
  assign w_reg0     = w_io && mem_addr[15:0] == 16'h0000;
  assign w_reg_stop = w_io && mem_addr[15:0] == 16'h0004;
  assign w_cnt      = w_io && mem_addr[15:2] == 14'h0001;
  assign w_rd       = rdy_in && !mem_wr;
  assign w_wr       = rdy_in && mem_wr;
  // Extra pointer bit distinguishes full (MSBs differ, rest equal) from empty.
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_rx_full  = (r_rx_wp ^ r_rx_rp) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full  = (r_tx_wp ^ r_tx_rp) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  assign w_rx_push  = rx_valid && !w_rx_full;
  assign w_rx_pop   = w_rd && w_reg0 && !w_rx_empty;
  assign w_tx_req   = w_wr && ((w_reg0 && mem_dout != 8'h00) || w_reg_stop);
  assign w_tx_push  = w_tx_req && !w_tx_full;
  assign w_tx_pop   = !w_tx_empty && tx_ready;
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
  logic [31:0] r_snap;
  assign w_cnt_word = (mem_addr[1:0] == 2'd0) ? r_cnt : r_snap;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_snap <= '0;
    else if (w_rd && w_cnt && mem_addr[1:0] == 2'd0) r_snap <= r_cnt;
`else
  assign w_cnt_word = r_cnt;
`endif
  assign w_cnt_byte = w_cnt_word[{mem_addr[1:0], 3'b000} +: 8];
  assign w_io_rd    = w_reg0 ? (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[FIFO_DEPTH_LOG2-1:0]]) :
                      w_cnt  ? w_cnt_byte : 8'h00;
  // Storage arrays carry no reset so they map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (w_wr && w_ram) r_ram[mem_addr[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
    r_ram_rd <= r_ram[mem_addr[RAM_ADDR_WIDTH-1:0]];
    if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_DEPTH_LOG2-1:0]] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_DEPTH_LOG2-1:0]] <= w_reg_stop ? 8'h00 : mem_dout;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sel_ram   <= 1'b0;
      r_io_q      <= 8'h00;
      r_prog_stop <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_cnt       <= '0;
      r_rx_wp     <= '0;
      r_rx_rp     <= '0;
      r_tx_wp     <= '0;
      r_tx_rp     <= '0;
    end else begin
      r_sel_ram   <= w_rd && w_ram;
      r_io_q      <= (w_rd && w_io) ? w_io_rd : 8'h00;
      r_prog_stop <= w_wr && w_reg_stop;
      r_tx_ovf    <= r_tx_ovf || (w_tx_req && w_tx_full);
      if (rdy_in) r_cnt <= r_cnt + 32'd1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
    end
  end
  assign mem_din     = r_sel_ram ? r_ram_rd : r_io_q;
  assign rx_ready    = !w_rx_full;
  assign tx_valid    = !w_tx_empty;
  assign tx_data     = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp[FIFO_DEPTH_LOG2-1:0]];
  assign prog_stop   = r_prog_stop;
  assign tx_overflow = r_tx_ovf;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed scenarios plus randomized traffic against a queue-based reference model of mem_io_responder.
module tb_mem_io_responder;
  logic        clk_in = 0, rst_in = 0, rdy_in = 0, mem_wr = 0;
  logic [31:0] mem_addr = 0;
  logic [7:0]  mem_dout = 0, mem_din, rx_data = 0, tx_data;
  logic        rx_valid = 0, rx_ready, tx_valid, tx_ready = 0, prog_stop, tx_overflow;
  int n_cmp = 0, n_err = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .prog_stop(prog_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  rxq[$], txq[$];
  logic [7:0]  ram_m [int];
  logic [31:0] cnt_m = 0, snap_m = 0;
  logic [7:0]  din_m = 0;
  bit          din_chk_m = 1, ps_m = 0, ovf_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    cnt_m = 0; snap_m = 0; din_m = 0; din_chk_m = 1; ps_m = 0; ovf_m = 0;
  endtask

  task automatic model_step();
    int rx_n, tx_n, k;
    logic [17:0] a;
    logic [7:0] tx_val;
    bit tx_req;
    rx_n = rxq.size(); tx_n = txq.size(); a = mem_addr[17:0];
    tx_req = 0; tx_val = 0; din_chk_m = 1; din_m = 0; ps_m = 0;
    if (rdy_in) begin
      if (!mem_wr) begin
        if (a < 18'h20000) begin
          din_chk_m = ram_m.exists(int'(a));
          if (din_chk_m) din_m = ram_m[int'(a)];
        end else if (a == 18'h30000) begin
          if (rx_n > 0) din_m = rxq.pop_front();
        end else if (a >= 18'h30004 && a <= 18'h30007) begin
          k = int'(a - 18'h30004);
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
          if (k == 0) snap_m = cnt_m;
          din_m = (k == 0) ? cnt_m[7:0] : 8'(snap_m >> (8 * k));
`else
          din_m = 8'(cnt_m >> (8 * k));
`endif
        end
      end else begin
        if (a < 18'h20000) ram_m[int'(a)] = mem_dout;
        if (a == 18'h30000 && mem_dout != 0) begin tx_req = 1; tx_val = mem_dout; end
        if (a == 18'h30004) begin tx_req = 1; tx_val = 0; ps_m = 1; end
      end
      cnt_m = cnt_m + 1;
    end
    if (tx_n > 0 && tx_ready) void'(txq.pop_front());
    if (tx_req) begin
      if (tx_n == 16) ovf_m = 1;
      else txq.push_back(tx_val);
    end
    if (rx_valid && rx_n < 16) rxq.push_back(rx_data);
  endtask

  initial forever begin
    @(posedge clk_in or negedge rst_in);
    if (!rst_in) model_reset();
    else model_step();
  end

  always @(negedge clk_in) begin
    chk("rx_ready", {31'b0, rx_ready}, {31'b0, rxq.size() < 16});
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() != 0});
    chk("tx_data", {24'b0, tx_data}, {24'b0, txq.size() != 0 ? txq[0] : 8'h00});
    chk("tx_overflow", {31'b0, tx_overflow}, {31'b0, ovf_m});
    chk("prog_stop", {31'b0, prog_stop}, {31'b0, ps_m});
    if (din_chk_m) chk("mem_din", {24'b0, mem_din}, {24'b0, din_m});
  end

  task automatic cpu(input logic rdy, input logic wr, input logic [31:0] addr, input logic [7:0] d);
    rdy_in = rdy; mem_wr = wr; mem_addr = addr; mem_dout = d;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle();
    cpu(1, 0, 32'h0002_0000, 8'h00);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [17:0] lo;
    case ($urandom_range(0, 6))
      0, 1:    lo = 18'($urandom_range(0, 63));
      2:       lo = 18'h1FFFF - 18'($urandom_range(0, 3));
      3:       lo = 18'h30000;
      4:       lo = 18'h30004 + 18'($urandom_range(0, 3));
      5:       lo = 18'h30000 + 18'($urandom_range(8, 40));
      default: lo = 18'h20000 + 18'($urandom_range(0, 255));
    endcase
    return {14'($urandom), lo};
  endfunction

  initial begin
    repeat (3) @(posedge clk_in);
    #2;
    chk("reset mem_din", {24'b0, mem_din}, 32'h00);
    chk("reset rx_ready", {31'b0, rx_ready}, 32'h1);
    chk("reset tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset tx_data", {24'b0, tx_data}, 32'h00);
    chk("reset prog_stop", {31'b0, prog_stop}, 32'h0);
    chk("reset tx_overflow", {31'b0, tx_overflow}, 32'h0);
    rst_in = 1;
    // RAM write then read with one-cycle latency
    cpu(1, 1, 32'h10, 8'hA5); tick();
    cpu(1, 0, 32'h10, 8'h00); tick();
    chk("ram read A5", {24'b0, mem_din}, 32'hA5);
    // RX: host pushes two bytes, CPU pops three times
    idle(); rx_valid = 1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 0; cpu(1, 0, 32'h30000, 8'h00); tick();
    chk("rx pop 41", {24'b0, mem_din}, 32'h41);
    tick();
    chk("rx pop 42", {24'b0, mem_din}, 32'h42);
    tick();
    chk("rx pop empty", {24'b0, mem_din}, 32'h00);
    chk("rx_ready high", {31'b0, rx_ready}, 32'h1);
    // TX: zero write ignored
    tx_ready = 1;
    cpu(1, 1, 32'h30000, 8'h48); tick();
    chk("tx head 48", {24'b0, tx_data}, 32'h48);
    cpu(1, 1, 32'h30000, 8'h00); tick();
    chk("tx zero ignored", {31'b0, tx_valid}, 32'h0);
    cpu(1, 1, 32'h30000, 8'h49); tick();
    chk("tx head 49", {24'b0, tx_data}, 32'h49);
    idle(); tick();
    // TX overflow on the 17th push
    tx_ready = 0;
    for (int i = 0; i < 17; i++) begin
      cpu(1, 1, 32'h30000, 8'h55); tick();
      if (i == 15) chk("no overflow at 16", {31'b0, tx_overflow}, 32'h0);
    end
    chk("overflow at 17", {31'b0, tx_overflow}, 32'h1);
    idle(); tx_ready = 1;
    repeat (16) tick();
    chk("tx drained", {31'b0, tx_valid}, 32'h0);
    // Program stop
    tx_ready = 0;
    cpu(1, 1, 32'h30004, 8'h99); tick();
    chk("prog_stop pulse", {31'b0, prog_stop}, 32'h1);
    chk("stop pushes 00", {23'b0, tx_valid, tx_data}, 32'h100);
    idle(); tick();
    chk("prog_stop one cycle", {31'b0, prog_stop}, 32'h0);
    tx_ready = 1; tick(); tx_ready = 0;
    // rdy_in low blocks writes and forces mem_din to zero
    cpu(0, 1, 32'h10, 8'h77); tick();
    chk("rdy low mem_din", {24'b0, mem_din}, 32'h00);
    cpu(1, 0, 32'h10, 8'h00); tick();
    chk("rdy low no write", {24'b0, mem_din}, 32'hA5);
    // Counter read around the 0xFF -> 0x100 carry
    idle();
    for (int i = 0; i < 1000 && cnt_m < 32'hFF; i++) tick();
    chk("counter preset", cnt_m, 32'hFF);
    cpu(1, 0, 32'h30004, 8'h00); tick();
    chk("cnt byte0", {24'b0, mem_din}, 32'hFF);
    cpu(1, 0, 32'h30005, 8'h00); tick();
`ifdef MEMIO_CYCLE_SNAPSHOT_EN
    chk("cnt byte1", {24'b0, mem_din}, 32'h00);
`else
    chk("cnt byte1", {24'b0, mem_din}, 32'h01);
`endif
    cpu(1, 0, 32'h30006, 8'h00); tick();
    chk("cnt byte2", {24'b0, mem_din}, 32'h00);
    cpu(1, 0, 32'h30007, 8'h00); tick();
    chk("cnt byte3", {24'b0, mem_din}, 32'h00);
    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_in = 0; tick(); rst_in = 1;
        chk("midreset tx_overflow", {31'b0, tx_overflow}, 32'h0);
        chk("midreset tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("midreset mem_din", {24'b0, mem_din}, 32'h00);
      end
      cpu(($urandom % 8) != 0, $urandom_range(0, 2) == 0, rnd_addr(),
          ($urandom % 4 == 0) ? 8'h00 : 8'($urandom));
      rx_valid = $urandom % 2;
      rx_data = 8'($urandom);
      tx_ready = ($urandom % 3) == 0;
      tick();
    end
    idle(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
